// File: rtl/reg_file_2r1w.sv
// Parametrised 2-read / 1-write register file with byte-enabled writes,
// registered reads with valid flags, optional write bypass and optional zero register.
module reg_file_2r1w #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG0  = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WrEn,
  input  logic [ADDR_WIDTH-1:0]   WrAddr,
  input  logic [WIDTH-1:0]        WrData,
  input  logic [WIDTH/8-1:0]      WrByteEn,
  input  logic                    RdEn_A,
  input  logic [ADDR_WIDTH-1:0]   RdAddr_A,
  output logic [WIDTH-1:0]        RdData_A,
  output logic                    RdValid_A,
  input  logic                    RdEn_B,
  input  logic [ADDR_WIDTH-1:0]   RdAddr_B,
  output logic [WIDTH-1:0]        RdData_B,
  output logic                    RdValid_B
);

  localparam int NB   = WIDTH / 8;
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic             vld_a_q, vld_b_q;

  logic             wr_eff;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_old, wr_merged;

  // Merged word serves both the array update and the bypass path.
  always_comb begin
    wr_eff = WrEn && ({1'b0, WrAddr} < DEPTH_W) &&
             !((ZERO_REG0 != 0) && (WrAddr == '0));
    wr_idx = WrAddr[IDXW-1:0];
    wr_old = regs_q[wr_idx];
    wr_merged = wr_old;
    for (int unsigned b = 0; b < NB; b++) begin
      if (WrByteEn[b]) wr_merged[8*b +: 8] = WrData[8*b +: 8];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_eff) begin
      regs_q[wr_idx] <= wr_merged;
    end
  end

  always_comb begin
    rd_a_d = '0;
    if ({1'b0, RdAddr_A} >= DEPTH_W)                        rd_a_d = '0;
    else if ((ZERO_REG0 != 0) && (RdAddr_A == '0))          rd_a_d = '0;
    else if ((BYPASS != 0) && wr_eff && (RdAddr_A == WrAddr)) rd_a_d = wr_merged;
    else                                                    rd_a_d = regs_q[RdAddr_A[IDXW-1:0]];
  end

  always_comb begin
    rd_b_d = '0;
    if ({1'b0, RdAddr_B} >= DEPTH_W)                        rd_b_d = '0;
    else if ((ZERO_REG0 != 0) && (RdAddr_B == '0))          rd_b_d = '0;
    else if ((BYPASS != 0) && wr_eff && (RdAddr_B == WrAddr)) rd_b_d = wr_merged;
    else                                                    rd_b_d = regs_q[RdAddr_B[IDXW-1:0]];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
    end else begin
      vld_a_q <= RdEn_A;
      vld_b_q <= RdEn_B;
      if (RdEn_A) rd_a_q <= rd_a_d;
      if (RdEn_B) rd_b_q <= rd_b_d;
    end
  end

  assign RdData_A  = rd_a_q;
  assign RdValid_A = vld_a_q;
  assign RdData_B  = rd_b_q;
  assign RdValid_B = vld_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: two configurations (bypass/full depth, and no-bypass/depth 12/zero reg)
// share stimulus; a behavioural model pushes expected read data, a negedge monitor checks it.
module tb_reg_file_2r1w;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WrEn = 1'b0;
  logic [3:0]  WrAddr = '0;
  logic [15:0] WrData = '0;
  logic [1:0]  WrByteEn = '0;
  logic        RdEn_A = 1'b0, RdEn_B = 1'b0;
  logic [3:0]  RdAddr_A = '0, RdAddr_B = '0;
  logic [15:0] da0, db0, da1, db1;
  logic        va0, vb0, va1, vb1;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4), .BYPASS(1), .ZERO_REG0(0)) u_a (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrByteEn(WrByteEn),
    .RdEn_A(RdEn_A), .RdAddr_A(RdAddr_A), .RdData_A(da0), .RdValid_A(va0),
    .RdEn_B(RdEn_B), .RdAddr_B(RdAddr_B), .RdData_B(db0), .RdValid_B(vb0));

  reg_file_2r1w #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4), .BYPASS(0), .ZERO_REG0(1)) u_b (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrByteEn(WrByteEn),
    .RdEn_A(RdEn_A), .RdAddr_A(RdAddr_A), .RdData_A(da1), .RdValid_A(va1),
    .RdEn_B(RdEn_B), .RdAddr_B(RdAddr_B), .RdData_B(db1), .RdValid_B(vb1));

  // Reference model: per-configuration storage and rules
  int          dep [2] = '{16, 12};
  bit          byp [2] = '{1'b1, 1'b0};
  bit          zr  [2] = '{1'b0, 1'b1};
  logic [15:0] mem [2][16];
  logic [15:0] q   [4][$];
  logic [15:0] last [4];

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] wd, logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = wd[7:0];
    if (be[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  function automatic bit eff(int c, bit we, int wa);
    return we && (wa < dep[c]) && !(zr[c] && wa == 0);
  endfunction

  function automatic logic [15:0] mread(int c, int a, bit we, int wa, logic [15:0] wd, logic [1:0] be);
    if (a >= dep[c]) return 16'h0000;
    if (zr[c] && a == 0) return 16'h0000;
    if (byp[c] && eff(c, we, wa) && a == wa) return merge(mem[c][a], wd, be);
    return mem[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 16; i++) mem[c][i] = '0;
    for (int p = 0; p < 4; p++) begin
      q[p].delete();
      last[p] = '0;
    end
  endtask

  task automatic idle();
    WrEn = 1'b0; WrByteEn = '0; RdEn_A = 1'b0; RdEn_B = 1'b0;
  endtask

  // Called at posedge+2; drives one edge worth of stimulus, returns at the next posedge+2.
  task automatic step(bit we, int wa, logic [15:0] wd, logic [1:0] be,
                      bit ea, int aa, bit eb, int ab);
    WrEn = we; WrAddr = 4'(wa); WrData = wd; WrByteEn = be;
    RdEn_A = ea; RdAddr_A = 4'(aa); RdEn_B = eb; RdAddr_B = 4'(ab);
    for (int c = 0; c < 2; c++) begin
      if (ea) q[2*c].push_back(mread(c, aa, we, wa, wd, be));
      if (eb) q[2*c+1].push_back(mread(c, ab, we, wa, wd, be));
    end
    for (int c = 0; c < 2; c++)
      if (eff(c, we, wa)) mem[c][wa] = merge(mem[c][wa], wd, be);
    @(posedge CLK); #2;
    idle();
  endtask

  task automatic mon_port(int p, logic v, logic [15:0] d);
    string nm;
    nm = $sformatf("port%0d", p);
    if (v) begin
      if (q[p].size() == 0) begin
        total++; bad++;
        $display("FAIL %s unexpected valid: data %h, no read outstanding", nm, d);
      end else begin
        last[p] = q[p].pop_front();
        chk({nm, " data"}, d, last[p]);
      end
    end else begin
      chk({nm, " hold"}, d, last[p]);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      mon_port(0, va0, da0);
      mon_port(1, vb0, db0);
      mon_port(2, va1, da1);
      mon_port(3, vb1, db1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    chk("rst_init dataA", da0, 16'h0000);
    chk("rst_init validA", {15'b0, va0}, 16'h0000);
    #2 RST = 1'b0;
    @(posedge CLK); #2;

    // Reset mid-operation
    step(1, 2, 16'hABCD, 2'b11, 0, 0, 0, 0);
    step(0, 0, 16'h0, 2'b00, 1, 2, 1, 2);
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst dataA u_a",  da0, 16'h0000);
    chk("rst dataB u_a",  db0, 16'h0000);
    chk("rst validA u_a", {15'b0, va0}, 16'h0000);
    chk("rst validB u_a", {15'b0, vb0}, 16'h0000);
    chk("rst dataA u_b",  da1, 16'h0000);
    chk("rst validB u_b", {15'b0, vb1}, 16'h0000);
    #1 RST = 1'b0;
    step(0, 0, 16'h0, 2'b00, 1, 2, 1, 2);
    chk("post-rst read reg2", da0, 16'h0000);

    // Dual read, then hold
    step(1, 2, 16'hABCD, 2'b11, 0, 0, 0, 0);
    step(1, 4, 16'h1234, 2'b11, 0, 0, 0, 0);
    step(0, 0, 16'h0, 2'b00, 1, 2, 1, 4);
    chk("dual A", da0, 16'hABCD);
    chk("dual B", db0, 16'h1234);
    chk("dual vA", {15'b0, va0}, 16'h0001);
    step(0, 0, 16'h0, 2'b00, 0, 0, 0, 0);
    chk("dual hold vA", {15'b0, va0}, 16'h0000);
    chk("dual hold A", da0, 16'hABCD);

    // Byte enables
    step(1, 2, 16'hFFFF, 2'b01, 0, 0, 0, 0);
    step(1, 2, 16'h0000, 2'b00, 0, 0, 0, 0);
    step(0, 0, 16'h0, 2'b00, 1, 2, 1, 2);
    chk("byte-en reg2", da0, 16'hABFF);

    // Bypass vs no bypass, full and partial byte enables
    step(1, 4, 16'h5A5A, 2'b11, 1, 4, 0, 0);
    chk("bypass on", da0, 16'h5A5A);
    chk("bypass off", da1, 16'h1234);
    step(0, 0, 16'h0, 2'b00, 1, 4, 0, 0);
    chk("after bypass off", da1, 16'h5A5A);
    step(1, 4, 16'h1234, 2'b11, 0, 0, 0, 0);
    step(1, 4, 16'h5A5A, 2'b10, 1, 4, 0, 0);
    chk("bypass byte-en", da0, 16'h5A34);

    // Zero register and out-of-range address
    step(1, 0, 16'hBEEF, 2'b11, 0, 0, 0, 0);
    step(0, 0, 16'h0, 2'b00, 1, 0, 0, 0);
    chk("zero reg0", da1, 16'h0000);
    chk("zero reg0 valid", {15'b0, va1}, 16'h0001);
    step(1, 13, 16'hBEEF, 2'b11, 0, 0, 0, 0);
    step(0, 0, 16'h0, 2'b00, 1, 13, 1, 13);
    chk("oob read u_b", db1, 16'h0000);
    chk("addr13 u_a", da0, 16'hBEEF);
    for (int i = 0; i < 12; i += 2) step(0, 0, 16'h0, 2'b00, 1, i, 1, i + 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 15), 16'($urandom), 2'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge CLK); #2;
      end
    end

    repeat (3) @(posedge CLK);
    #2;
    for (int p = 0; p < 4; p++)
      chk($sformatf("port%0d outstanding", p), 16'(q[p].size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
